rice_bus_ram_slave: RTL and testbench
=====================================

RICE_BUS_RAM_SLAVE -- requirements
Module: rice_bus_ram_slave

Interface
REQ-001 SHALL have parameter XLEN, default 32, data and address width in bits.
REQ-002 SHALL have parameter SIZE, default 4096, memory size in bytes; a power of two and at least XLEN/8.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, extra cycles between request acceptance and response; 0 is legal.
REQ-004 SHALL have port i_clk  input  1  sole clock; all logic updates on its rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port bus_if  rice_bus_if.slave  -  responder end of the bus that the core's load/store unit drives as master.
REQ-007 SHALL have bus_if.request_valid  input  1  master presents a request.
REQ-008 SHALL have bus_if.request_ready  output  1  slave accepts the request this cycle.
REQ-009 SHALL have bus_if.address  input  XLEN  byte address.
REQ-010 SHALL have bus_if.write  input  1  1 = store, 0 = load.
REQ-011 SHALL have bus_if.write_data  input  XLEN  store data.
REQ-012 SHALL have bus_if.strobe  input  XLEN/8  byte enables for stores.
REQ-013 SHALL have bus_if.response_valid  output  1  response is present.
REQ-014 SHALL have bus_if.response_ready  input  1  master consumes the response.
REQ-015 SHALL have bus_if.read_data  output  XLEN  load data; 0 for stores and for errors.
REQ-016 SHALL have bus_if.error  output  1  access fault, qualified by response_valid.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, WAIT, RESPOND.
REQ-018 SHALL drive request_ready high only in IDLE; a request is accepted when request_valid and request_ready are both high.
REQ-019 SHALL capture address, write, write_data and strobe on acceptance.
REQ-020 SHALL go IDLE->WAIT on acceptance with WAIT_CYCLES>0, loading a down-counter with WAIT_CYCLES-1.
REQ-021 SHALL go IDLE->RESPOND on acceptance when WAIT_CYCLES=0, so response_valid is high the cycle after acceptance.
REQ-022 SHALL decrement the counter in WAIT and go WAIT->RESPOND when it reaches 0, so response_valid first rises WAIT_CYCLES+1 cycles after acceptance.
REQ-023 SHALL hold response_valid, read_data and error stable in RESPOND until response_ready is high, then return to IDLE.
REQ-024 SHALL keep request_ready low in the RESPOND exit cycle, so at most one request is outstanding and no back-to-back acceptance occurs.
REQ-025 SHALL perform a store in the cycle it enters RESPOND, writing only the bytes whose strobe bit is set.
REQ-026 SHALL return a load as the full aligned word at address[log2(SIZE)-1:log2(XLEN/8)].
REQ-027 SHALL flag error when address >= SIZE; the store is suppressed and read_data is 0.
REQ-028 SHALL flag error when the address is misaligned (address[log2(XLEN/8)-1:0] != 0); the store is suppressed and read_data is 0.
REQ-029 SHALL treat a store with strobe = 0 as a successful no-op response with error = 0.
REQ-030 SHALL ignore request_valid outside IDLE.

Reset
REQ-031 SHALL, with i_rst high at a clock edge, enter IDLE, clear the counter, and drive response_valid=0, error=0 and read_data=0; request_ready becomes 1 the first cycle after i_rst is released.
REQ-032 SHALL drop any in-flight transaction on reset without a response; a store not yet committed is not written.
REQ-033 SHALL NOT clear memory contents on reset.

Structure
REQ-034 SHALL place the FSM state enum (rice_bus_ram_state) in shared package rice_bus_pkg.
REQ-035 SHALL use one sub-module, rice_bus_ram_array: a byte-enabled synchronous-write, combinational-read storage array.

Verification
REQ-036 SHALL test: WAIT_CYCLES=1; store 0xDEADBEEF to 0x10 with strobe 0xF, then load 0x10 -> each response_valid 2 cycles after acceptance; read_data=0xDEADBEEF, error=0.
REQ-037 SHALL test: word 0x11223344 at 0x20; store 0xAABBCCDD with strobe 0x5; load 0x20 -> 0x11BB33DD.
REQ-038 SHALL test: load 0x1002 with SIZE=4096 -> error=1, read_data=0; load 0x0003 -> error=1; memory unchanged.
REQ-039 SHALL test: response_ready held low 5 cycles -> response_valid and read_data stable; request_ready=0 throughout; second request accepted only after the response handshake.
REQ-040 SHALL test: WAIT_CYCLES=0 -> response the cycle after acceptance; with WAIT_CYCLES=3, i_rst asserted in WAIT during a store -> no response, and a later load returns the old data.

Source files
------------

// File: rtl/rice_bus_pkg.sv
// Shared types for the rice bus RAM slave.
// Holds the responder FSM state encoding.
package rice_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESPOND
  } rice_bus_ram_state;

endpackage

// File: rtl/rice_bus_if.sv
// Load/store bus between the core LSU (master)
// and a memory-mapped responder (slave).
interface rice_bus_if #(
  parameter int XLEN = 32
);

  logic              request_valid;
  logic              request_ready;
  logic [XLEN-1:0]   address;
  logic              write;
  logic [XLEN-1:0]   write_data;
  logic [XLEN/8-1:0] strobe;
  logic              response_valid;
  logic              response_ready;
  logic [XLEN-1:0]   read_data;
  logic              error;

  modport master (
    output request_valid, address, write,
    output write_data, strobe, response_ready,
    input  request_ready, response_valid,
    input  read_data, error
  );

  modport slave (
    input  request_valid, address, write,
    input  write_data, strobe, response_ready,
    output request_ready, response_valid,
    output read_data, error
  );

endinterface

// File: rtl/rice_bus_ram_array.sv
// Word-organised storage with per-byte write enables,
// synchronous write and combinational read.
module rice_bus_ram_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [XLEN/8-1:0] strb_i,
  input  logic [IW-1:0]     addr_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   rdata_o
);

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (strb_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/rice_bus_ram_slave.sv
// Single-outstanding RAM responder on the rice bus
// with a configurable response latency.
module rice_bus_ram_slave
  import rice_bus_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int SIZE        = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input logic       i_clk,
  input logic       i_rst,
  rice_bus_if.slave bus_if
);

  localparam int NB    = XLEN / 8;
  localparam int DEPTH = SIZE / NB;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OFFW  = $clog2(NB);

  rice_bus_ram_state state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;

  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [NB-1:0]   strb_q;
  logic            write_q, err_q;

  logic            accept, enter_rsp, fault, we;
  logic [XLEN-1:0] cur_addr, cur_wdata, mem_rdata;
  logic [NB-1:0]   cur_strb;
  logic            cur_write;
  logic [IW-1:0]   idx;

  assign accept = bus_if.request_valid
                & bus_if.request_ready;

  // With zero wait the response is formed on the
  // acceptance edge, straight from the bus.
  assign cur_addr  = (state_q == ST_IDLE) ?
                     bus_if.address : addr_q;
  assign cur_wdata = (state_q == ST_IDLE) ?
                     bus_if.write_data : wdata_q;
  assign cur_strb  = (state_q == ST_IDLE) ?
                     bus_if.strobe : strb_q;
  assign cur_write = (state_q == ST_IDLE) ?
                     bus_if.write : write_q;

  assign fault = (cur_addr >= XLEN'(SIZE))
              || ((cur_addr & XLEN'(NB - 1)) != '0);
  assign idx   = IW'(cur_addr >> OFFW);

  assign enter_rsp =
      (state_q == ST_IDLE && accept && WAIT_CYCLES == 0)
   || (state_q == ST_WAIT && cnt_q == '0);

  assign we = enter_rsp & cur_write & ~fault & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESPOND;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 32'(WAIT_CYCLES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESPOND;
        else             cnt_d   = cnt_q - 32'd1;
      end
      ST_RESPOND: begin
        if (bus_if.response_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_if.request_ready  = (state_q == ST_IDLE) & ~i_rst;
    bus_if.response_valid = (state_q == ST_RESPOND);
    bus_if.read_data      = rdata_q;
    bus_if.error          = err_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus_if.address;
        wdata_q <= bus_if.write_data;
        strb_q  <= bus_if.strobe;
        write_q <= bus_if.write;
      end
      if (enter_rsp) begin
        err_q   <= fault;
        rdata_q <= (cur_write | fault) ? '0 : mem_rdata;
      end
    end
  end

  rice_bus_ram_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk_i   (i_clk),
    .we_i    (we),
    .strb_i  (cur_strb),
    .addr_i  (idx),
    .wdata_i (cur_wdata),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_rice_bus_ram_slave.sv
// Randomised bench for rice_bus_ram_slave with three
// latencies (1, 0, 3) against a byte-array model.
module tb_rice_bus_ram_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        rst     [3];
  logic        rv      [3];
  logic        wr      [3];
  logic [31:0] addr    [3];
  logic [31:0] wd      [3];
  logic [3:0]  strb    [3];
  logic        rsp_rdy [3];
  logic        rr      [3];
  logic        rsv     [3];
  logic        err     [3];
  logic [31:0] rd      [3];

  logic [7:0] mm [3][256];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int WC = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    rice_bus_if #(.XLEN(32)) bus ();
    assign bus.request_valid  = rv[g];
    assign bus.address        = addr[g];
    assign bus.write          = wr[g];
    assign bus.write_data     = wd[g];
    assign bus.strobe         = strb[g];
    assign bus.response_ready = rsp_rdy[g];
    assign rr[g]  = bus.request_ready;
    assign rsv[g] = bus.response_valid;
    assign rd[g]  = bus.read_data;
    assign err[g] = bus.error;
    rice_bus_ram_slave #(
      .XLEN        (32),
      .SIZE        (4096),
      .WAIT_CYCLES (WC)
    ) dut (
      .i_clk  (clk),
      .i_rst  (rst[g]),
      .bus_if (bus.slave)
    );
  end

  function automatic int wc_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
  endfunction

  task automatic chk(string tag, logic [63:0] got,
                     logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural memory: plain bytes, error by range/alignment.
  task automatic model(int k, bit w, logic [31:0] a,
                       logic [31:0] d, logic [3:0] s,
                       output logic [31:0] r,
                       output bit e);
    e = (a >= 32'd4096) || (a % 4 != 0);
    r = '0;
    if (!e) begin
      for (int i = 0; i < 4; i++) begin
        if (w) begin
          if (s[i]) mm[k][a + i] = d[8*i +: 8];
        end else begin
          r[8*i +: 8] = mm[k][a + i];
        end
      end
    end
  endtask

  task automatic txn(int k, bit w, logic [31:0] a,
                     logic [31:0] d, logic [3:0] s,
                     int hold, string tag,
                     output logic [31:0] got,
                     output logic got_e);
    logic [31:0] er;
    bit          ee;
    int          lat;
    int          guard;
    @(negedge clk);
    rv[k] = 1'b1; wr[k] = w; addr[k] = a;
    wd[k] = d; strb[k] = s; rsp_rdy[k] = 1'b0;
    guard = 0;
    while (!rr[k] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "/rdy"}, 64'(rr[k]), 64'd1);
    @(posedge clk);
    #1 rv[k] = 1'b0;
    model(k, w, a, d, s, er, ee);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsv[k] && lat < 20);
    chk({tag, "/lat"}, 64'(lat), 64'(wc_of(k) + 1));
    got   = rd[k];
    got_e = err[k];
    chk({tag, "/data"}, 64'(got), 64'(er));
    chk({tag, "/err"}, 64'(got_e), 64'(ee));
    chk({tag, "/busy"}, 64'(rr[k]), 64'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "/hvld"}, 64'(rsv[k]), 64'd1);
      chk({tag, "/hdat"}, 64'(rd[k]), 64'(got));
      chk({tag, "/herr"}, 64'(err[k]), 64'(got_e));
      chk({tag, "/hrdy"}, 64'(rr[k]), 64'd0);
    end
    rsp_rdy[k] = 1'b1;
    @(posedge clk);
    #1 rsp_rdy[k] = 1'b0;
    @(negedge clk);
    chk({tag, "/done"}, 64'(rsv[k]), 64'd0);
    chk({tag, "/idle"}, 64'(rr[k]), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, old, a;
    logic        e;
    int          kind;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; rv[k] = 1'b0; wr[k] = 1'b0;
      addr[k] = '0; wd[k] = '0; strb[k] = '0;
      rsp_rdy[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst/vld", 64'(rsv[k]), 64'd0);
      chk("rst/err", 64'(err[k]), 64'd0);
      chk("rst/dat", 64'(rd[k]), 64'd0);
      chk("rst/rdy", 64'(rr[k]), 64'd0);
      rst[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++)
      chk("rel/rdy", 64'(rr[k]), 64'd1);

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++)
        txn(k, 1, 32'(i * 4), $urandom, 4'hF, 0,
            "fill", r, e);

    txn(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "st10", r, e);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0, "ld10", r, e);
    chk("ld10/val", 64'(r), 64'hDEADBEEF);
    chk("ld10/e", 64'(e), 64'd0);

    txn(0, 1, 32'h20, 32'h11223344, 4'hF, 0, "st20", r, e);
    txn(0, 1, 32'h20, 32'hAABBCCDD, 4'h5, 0, "stb5", r, e);
    txn(0, 0, 32'h20, 32'h0, 4'h0, 0, "ld20", r, e);
    chk("ld20/val", 64'(r), 64'h11BB33DD);

    txn(0, 0, 32'h1002, 32'h0, 4'h0, 0, "oor", r, e);
    chk("oor/e", 64'(e), 64'd1);
    chk("oor/val", 64'(r), 64'd0);
    txn(0, 0, 32'h3, 32'h0, 4'h0, 0, "mis", r, e);
    chk("mis/e", 64'(e), 64'd1);
    txn(0, 1, 32'h12, 32'h0, 4'hF, 0, "mis_st", r, e);
    chk("mis_st/e", 64'(e), 64'd1);
    txn(0, 1, 32'h10, 32'h55, 4'h0, 0, "nostrb", r, e);
    chk("nostrb/e", 64'(e), 64'd0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0, "ld10b", r, e);
    chk("ld10b/val", 64'(r), 64'hDEADBEEF);

    txn(0, 0, 32'h20, 32'h0, 4'h0, 5, "hold", r, e);
    chk("hold/val", 64'(r), 64'h11BB33DD);
    txn(1, 0, 32'h20, 32'h0, 4'h0, 2, "wc0", r, e);

    txn(2, 0, 32'h40, 32'h0, 4'h0, 0, "pre", old, e);
    @(negedge clk);
    rv[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h40;
    wd[2] = ~old; strb[2] = 4'hF;
    chk("abort/rdy", 64'(rr[2]), 64'd1);
    @(posedge clk);
    #1 rv[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    @(negedge clk);
    rst[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort/vld", 64'(rsv[2]), 64'd0);
    end
    txn(2, 0, 32'h40, 32'h0, 4'h0, 0, "post", r, e);
    chk("post/old", 64'(r), 64'(old));

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        kind = int'($urandom_range(0, 9));
        if (kind == 0)
          a = $urandom | 32'h0000_1000;
        else if (kind == 1)
          a = 32'($urandom_range(0, 63) * 4
                  + $urandom_range(1, 3));
        else
          a = 32'($urandom_range(0, 63) * 4);
        txn(k, 1'($urandom_range(0, 1)), a, $urandom,
            4'($urandom), int'($urandom_range(0, 3)),
            "rnd", r, e);
      end
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
